// File: rtl/i2c_tof_target.sv
// i2c_tof_target: I2C target that emulates the ToF sensor side of the link.
// It decodes a 7-bit address, a 16-bit big-endian register pointer and burst
// writes/reads, and backs them with an external byte memory.
//
// Ports:
//   clk        system clock; SCL/SDA are oversampled on it
//   rst_n      asynchronous active-low reset
//   scl_in     raw SCL pad level
//   sda_in     raw SDA pad level
//   sda_oe     1 = pull SDA low, 0 = release
//   mem_addr   byte address into the backing memory
//   mem_wdata  write data
//   mem_we     single-cycle write strobe
//   mem_re     single-cycle read strobe
//   mem_rdata  read data, valid one clk after mem_re
//   busy       high from an addressed START until STOP or abort
module i2c_tof_target #(
  parameter logic [6:0] DEV_ADDR = 7'h29,
  parameter int         SDA_HOLD = 4  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t state, state_d;

  // [1:0] two-stage synchronizer, [2] history for edge detection
  logic [2:0]  scl_q, sda_q;
  logic [2:0]  bit_cnt;
  logic        phase;     // ACK states: set once the fall ending bit 8 was seen
  logic        rw;
  logic [7:0]  rx, tx, ptr_hi;
  logic [15:0] ptr;
  logic        re_d;
  logic        hold_act, pend;
  logic [7:0]  hold_cnt;

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start, stop, byte_done;
  logic [7:0] rx_nxt;

  assign scl_s = scl_q[1];
  assign scl_h = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_h = sda_q[2];

  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start     = scl_s & scl_h & ~sda_s & sda_h;
  assign stop      = scl_s & scl_h & sda_s & ~sda_h;
  assign rx_nxt    = {rx[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  // Control decoded from the current state and bus events
  logic pend_d, do_we, do_re, ld_ptr, ld_ptr_hi, shift_tx, busy_set, busy_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    pend_d    = 1'b0;   // every SCL fall releases SDA unless a state drives it
    do_we     = 1'b0;
    do_re     = 1'b0;
    ld_ptr    = 1'b0;
    ld_ptr_hi = 1'b0;
    shift_tx  = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      busy_clr = 1'b1;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state)
        ADDR: if (byte_done) begin
          if (rx_nxt[7:1] == DEV_ADDR) begin
            state_d  = ADDR_ACK;
            busy_set = 1'b1;
            do_re    = rx_nxt[0];  // prefetch first read byte during the ACK
          end else begin
            state_d  = IGNORE;
            busy_clr = 1'b1;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase)  pend_d = 1'b1;
          else if (rw) begin
            state_d = RD_DATA;
            pend_d  = ~tx[7];
          end else     state_d = PTR_HI;
        end
        PTR_HI: if (byte_done) begin
          state_d   = PTR_HI_ACK;
          ld_ptr_hi = 1'b1;
        end
        PTR_HI_ACK: if (scl_fall) begin
          if (!phase) pend_d  = 1'b1;
          else        state_d = PTR_LO;
        end
        PTR_LO: if (byte_done) begin
          state_d = PTR_LO_ACK;
          ld_ptr  = 1'b1;
        end
        PTR_LO_ACK: if (scl_fall) begin
          if (!phase) pend_d  = 1'b1;
          else        state_d = WR_DATA;
        end
        WR_DATA: if (byte_done) begin
          state_d = WR_ACK;
          do_we   = 1'b1;
        end
        WR_ACK: if (scl_fall) begin
          if (!phase) pend_d  = 1'b1;
          else        state_d = WR_DATA;
        end
        RD_DATA: begin
          // bit_cnt==0 only on the first fall after RD_ACK: MSB not yet shifted
          if (scl_fall) begin
            if (bit_cnt != 3'd0) begin
              shift_tx = 1'b1;
              pend_d   = ~tx[6];
            end else begin
              pend_d   = ~tx[7];
            end
          end
          if (byte_done) state_d = RD_ACK;
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            state_d = RD_DATA;
            do_re   = 1'b1;
          end else begin
            state_d  = IGNORE;
            busy_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q     <= 3'b111;  // bus idles high; avoids a false edge after reset
      sda_q     <= 3'b111;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      rw        <= 1'b0;
      rx        <= '0;
      tx        <= '0;
      ptr_hi    <= '0;
      ptr       <= '0;
      re_d      <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      hold_act  <= 1'b0;
      hold_cnt  <= '0;
      pend      <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};

      if (start || stop || (state_d != state)) bit_cnt <= '0;
      else if (scl_rise)                       bit_cnt <= bit_cnt + 3'd1;

      if (start || stop || (state_d != state)) phase <= 1'b0;
      else if (scl_fall)                       phase <= 1'b1;

      if (scl_rise) rx <= rx_nxt;
      if (byte_done && (state == ADDR)) rw <= rx_nxt[0];

      // Strobes are committed on the SCL rise and issue regardless of a
      // following START/STOP.
      mem_we <= do_we;
      mem_re <= do_re;
      re_d   <= mem_re;
      if (do_we) begin
        mem_addr  <= ptr;
        mem_wdata <= rx_nxt;
        ptr       <= ptr + 16'd1;
      end else if (do_re) begin
        mem_addr  <= ptr;
        ptr       <= ptr + 16'd1;
      end else if (ld_ptr) begin
        ptr       <= {ptr_hi, rx_nxt};
      end
      if (ld_ptr_hi) ptr_hi <= rx_nxt;

      if (re_d)          tx <= mem_rdata;
      else if (shift_tx) tx <= {tx[6:0], 1'b0};

      if (busy_clr)      busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;

      // SDA only changes SDA_HOLD clocks after a detected SCL fall
      if (start || stop) begin
        hold_act <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (scl_fall) begin
        hold_act <= 1'b1;
        hold_cnt <= '0;
        pend     <= pend_d;
      end else if (hold_act) begin
        if (hold_cnt == 8'(SDA_HOLD - 1)) begin
          sda_oe   <= pend;
          hold_act <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_tof_target.sv
module tb_i2c_tof_target;
  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, mem_we, mem_re, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  assign sda_bus = sda_m & ~sda_oe;  // open-drain wired-AND

  always #5 clk = ~clk;

  i2c_tof_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [7:0]  mem [0:65535];
  int          n_cmp = 0, n_err = 0;
  logic [23:0] exp_wr[$], obs_wr[$];
  logic [15:0] exp_rd[$], obs_rd[$];
  int          oe_hi_viol = 0;
  logic        oe_prev = 1'b0;
  logic        oe_seen = 1'b0, busy_seen = 1'b0, strobe_seen = 1'b0;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (mem_we) begin
      obs_wr.push_back({mem_addr, mem_wdata});
      mem[mem_addr] = mem_wdata;
    end
    if (mem_re) obs_rd.push_back(mem_addr);
    if (sda_oe && !oe_prev && scl) oe_hi_viol++;
    oe_prev = sda_oe;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (mem_we || mem_re) strobe_seen = 1'b1;
  end

  task automatic wq(int n = 1);
    repeat (n * Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(2);
    scl = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    ack = sda_bus;
    wq();
    scl = 1'b0; wq();
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; wq();
      scl = 1'b1; wq();
      d = {d[6:0], sda_bus};
      wq();
      scl = 1'b0; wq();
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wq(2);
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({mem_we, mem_re} !== 2'b00) begin n_err++; $display("FAIL rst_strobes: got %b want 00", {mem_we, mem_re}); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata); end
    rst_n = 1'b1;
    wq();
  endtask

  task automatic test_write();
    logic       ack;
    logic [7:0] d;
    logic [7:0] bytes [5];
    bytes = '{8'h52, 8'h2C, 8'h00, 8'hA5, 8'h3C};
    exp_wr.push_back({16'h2C00, 8'hA5});
    exp_wr.push_back({16'h2C01, 8'h3C});
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      wbyte(bytes[i], ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_ack[%0d]: got %b want 0", i, ack); end
      if (i == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
      end
    end
    i2c_stop();
    wq(2);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    while (exp_wr.size() > 0) begin
      n_cmp++;
      if (obs_wr.size() == 0) begin n_err++; $display("FAIL wr_sb: missing write, want %h", exp_wr.pop_front()); end
      else if (obs_wr[0] !== exp_wr[0]) begin n_err++; $display("FAIL wr_sb: got %h want %h", obs_wr.pop_front(), exp_wr.pop_front()); end
      else begin void'(obs_wr.pop_front()); void'(exp_wr.pop_front()); end
    end
    n_cmp++; if (obs_wr.size() != 0 || obs_rd.size() != 0) begin n_err++; $display("FAIL wr_extra: got %0d/%0d strobes want 0/0", obs_wr.size(), obs_rd.size()); end
    obs_wr.delete(); obs_rd.delete();
    // pointer must now sit at 0x2C02
    mem[16'h2C02] = 8'h5A;
    exp_rd.push_back(16'h2C02);
    i2c_start();
    wbyte(8'h53, ack);
    rbyte(1'b1, d);
    i2c_stop();
    wq(2);
    n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL ptr_after_wr_data: got %h want 5a", d); end
    while (exp_rd.size() > 0) begin
      n_cmp++;
      if (obs_rd.size() == 0) begin n_err++; $display("FAIL ptr_after_wr_re: missing read, want %h", exp_rd.pop_front()); end
      else if (obs_rd[0] !== exp_rd[0]) begin n_err++; $display("FAIL ptr_after_wr_re: got %h want %h", obs_rd.pop_front(), exp_rd.pop_front()); end
      else begin void'(obs_rd.pop_front()); void'(exp_rd.pop_front()); end
    end
    obs_rd.delete();
  endtask

  task automatic test_ptr_read();
    logic       ack;
    logic [7:0] d0, d1;
    mem[16'h2C00] = 8'h11;
    mem[16'h2C01] = 8'h22;
    exp_rd.push_back(16'h2C00);
    exp_rd.push_back(16'h2C01);
    i2c_start();
    wbyte(8'h52, ack);
    wbyte(8'h2C, ack);
    wbyte(8'h00, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_ptr_ack: got %b want 0", ack); end
    i2c_start();
    wbyte(8'h53, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    rbyte(1'b0, d0);
    rbyte(1'b1, d1);
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release_nack: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_nack: got %b want 0", busy); end
    i2c_stop();
    wq(2);
    n_cmp++; if (d0 !== 8'h11) begin n_err++; $display("FAIL rd_byte0: got %h want 11", d0); end
    n_cmp++; if (d1 !== 8'h22) begin n_err++; $display("FAIL rd_byte1: got %h want 22", d1); end
    while (exp_rd.size() > 0) begin
      n_cmp++;
      if (obs_rd.size() == 0) begin n_err++; $display("FAIL rd_sb: missing read, want %h", exp_rd.pop_front()); end
      else if (obs_rd[0] !== exp_rd[0]) begin n_err++; $display("FAIL rd_sb: got %h want %h", obs_rd.pop_front(), exp_rd.pop_front()); end
      else begin void'(obs_rd.pop_front()); void'(exp_rd.pop_front()); end
    end
    n_cmp++; if (obs_rd.size() != 0 || obs_wr.size() != 0) begin n_err++; $display("FAIL rd_extra: got %0d/%0d strobes want 0/0", obs_rd.size(), obs_wr.size()); end
    obs_wr.delete(); obs_rd.delete();
  endtask

  task automatic test_bad_addr();
    logic ack0, ack1;
    oe_seen = 1'b0; busy_seen = 1'b0; strobe_seen = 1'b0;
    i2c_start();
    wbyte(8'h54, ack0);
    wbyte(8'h2C, ack1);
    i2c_stop();
    wq(2);
    n_cmp++; if ({ack0, ack1} !== 2'b11) begin n_err++; $display("FAIL bad_addr_ack: got %b want 11", {ack0, ack1}); end
    n_cmp++; if (oe_seen !== 1'b0) begin n_err++; $display("FAIL bad_addr_oe: got %b want 0", oe_seen); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL bad_addr_busy: got %b want 0", busy_seen); end
    n_cmp++; if (strobe_seen !== 1'b0) begin n_err++; $display("FAIL bad_addr_strobe: got %b want 0", strobe_seen); end
    obs_wr.delete(); obs_rd.delete();
  endtask

  task automatic test_wrap();
    logic       ack;
    logic [7:0] bytes [5];
    bytes = '{8'h52, 8'hFF, 8'hFF, 8'h01, 8'h02};
    exp_wr.push_back({16'hFFFF, 8'h01});
    exp_wr.push_back({16'h0000, 8'h02});
    i2c_start();
    for (int i = 0; i < 5; i++) wbyte(bytes[i], ack);
    i2c_stop();
    wq(2);
    while (exp_wr.size() > 0) begin
      n_cmp++;
      if (obs_wr.size() == 0) begin n_err++; $display("FAIL wrap_sb: missing write, want %h", exp_wr.pop_front()); end
      else if (obs_wr[0] !== exp_wr[0]) begin n_err++; $display("FAIL wrap_sb: got %h want %h", obs_wr.pop_front(), exp_wr.pop_front()); end
      else begin void'(obs_wr.pop_front()); void'(exp_wr.pop_front()); end
    end
    n_cmp++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL wrap_extra: got %0d writes want 0", obs_wr.size()); end
    obs_wr.delete(); obs_rd.delete();
  endtask

  task automatic test_partial();
    logic ack;
    i2c_start();
    wbyte(8'h52, ack);
    wbyte(8'h10, ack);
    wbyte(8'h00, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    wq(2);
    n_cmp++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL partial_no_we: got %0d writes want 0", obs_wr.size()); end
    exp_wr.push_back({16'h1000, 8'h77});
    i2c_start();
    wbyte(8'h52, ack);
    wbyte(8'h10, ack);
    wbyte(8'h00, ack);
    wbyte(8'h77, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL partial_next_ack: got %b want 0", ack); end
    i2c_stop();
    wq(2);
    while (exp_wr.size() > 0) begin
      n_cmp++;
      if (obs_wr.size() == 0) begin n_err++; $display("FAIL partial_sb: missing write, want %h", exp_wr.pop_front()); end
      else if (obs_wr[0] !== exp_wr[0]) begin n_err++; $display("FAIL partial_sb: got %h want %h", obs_wr.pop_front(), exp_wr.pop_front()); end
      else begin void'(obs_wr.pop_front()); void'(exp_wr.pop_front()); end
    end
    obs_wr.delete(); obs_rd.delete();
  endtask

  task automatic test_reset_mid();
    logic       ack;
    logic [7:0] d;
    int         t;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h52 >> i));
    sda_m = 1'b1;
    t = 0;
    while (sda_oe !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
    n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_ack_drive: got %b want 1", sda_oe); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if ({busy, mem_we, mem_re} !== 3'b000) begin n_err++; $display("FAIL rstmid_outs: got %b want 000", {busy, mem_we, mem_re}); end
    wq();
    rst_n = 1'b1;
    wq();
    scl = 1'b1;
    wq();
    obs_wr.delete(); obs_rd.delete();
    // pointer is back at its reset value 0x0000
    mem[16'h0000] = 8'hC3;
    exp_rd.push_back(16'h0000);
    i2c_start();
    wbyte(8'h53, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstmid_next_ack: got %b want 0", ack); end
    rbyte(1'b1, d);
    i2c_stop();
    wq(2);
    n_cmp++; if (d !== 8'hC3) begin n_err++; $display("FAIL rstmid_rd_data: got %h want c3", d); end
    while (exp_rd.size() > 0) begin
      n_cmp++;
      if (obs_rd.size() == 0) begin n_err++; $display("FAIL rstmid_sb: missing read, want %h", exp_rd.pop_front()); end
      else if (obs_rd[0] !== exp_rd[0]) begin n_err++; $display("FAIL rstmid_sb: got %h want %h", obs_rd.pop_front(), exp_rd.pop_front()); end
      else begin void'(obs_rd.pop_front()); void'(exp_rd.pop_front()); end
    end
    obs_wr.delete(); obs_rd.delete();
  endtask

  initial begin
    mem_rdata = 8'h00;
    test_reset();
    test_write();
    test_ptr_read();
    test_bad_addr();
    test_wrap();
    test_partial();
    test_reset_mid();
    n_cmp++; if (oe_hi_viol != 0) begin n_err++; $display("FAIL oe_while_scl_high: got %0d events want 0", oe_hi_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
